// File: rtl/openddr_cmd_sequencer.sv
// DDR command sequencer: per-bank open-row tracking with tRCD/tRP/tRAS/tRFC timing,
// one request in flight, refresh taking priority over new requests.
//
// state    | meaning
// IDLE     | waiting for a request or refresh (acts only once rdy_q is set)
// PRE      | row miss, waiting for tRAS before PRE
// ACT      | waiting for tRP before ACT
// RW       | waiting for tRCD before RD/WR
// PREA     | refresh, waiting for tRAS on every bank before PREA
// REF      | waiting for tRP before REF
// WAIT_RFC | waiting out tRFC after REF
module openddr_cmd_sequencer #(
    parameter int BANK_WIDTH = 3,
    parameter int ROW_WIDTH  = 16,
    parameter int COL_WIDTH  = 10,
    parameter int T_RCD      = 4,
    parameter int T_RP       = 4,
    parameter int T_RAS      = 10,
    parameter int T_RFC      = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [BANK_WIDTH-1:0]      req_bank,
    input  logic [ROW_WIDTH-1:0]       req_row,
    input  logic [COL_WIDTH-1:0]       req_col,
    input  logic                       ref_req,
    output logic                       ref_ack,
    output logic                       cmd_valid,
    output logic [2:0]                 cmd_type,
    output logic [BANK_WIDTH-1:0]      cmd_bank,
    output logic [ROW_WIDTH-1:0]       cmd_row,
    output logic [COL_WIDTH-1:0]       cmd_col,
    output logic [(1<<BANK_WIDTH)-1:0] bank_open
);
    localparam int NB = 1 << BANK_WIDTH;
    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_ACT  = 3'd1;
    localparam logic [2:0] C_RD   = 3'd2;
    localparam logic [2:0] C_WR   = 3'd3;
    localparam logic [2:0] C_PRE  = 3'd4;
    localparam logic [2:0] C_REF  = 3'd5;
    localparam logic [2:0] C_PREA = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_ACT, S_RW, S_PREA, S_REF, S_WAIT_RFC
    } state_t;

    state_t                 state_q, state_d;
    logic                   rdy_q, rdy_d;
    logic [7:0]             wait_q, wait_d;
    logic [NB-1:0]          open_q, open_d;
    logic [ROW_WIDTH-1:0]   row_q [NB];
    logic [ROW_WIDTH-1:0]   row_d [NB];
    logic [7:0]             tras_q [NB];
    logic [7:0]             tras_d [NB];
    logic                   rq_write_q, rq_write_d;
    logic [BANK_WIDTH-1:0]  rq_bank_q, rq_bank_d;
    logic [ROW_WIDTH-1:0]   rq_row_q, rq_row_d;
    logic [COL_WIDTH-1:0]   rq_col_q, rq_col_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [2:0]             cmd_type_q, cmd_type_d;
    logic [BANK_WIDTH-1:0]  cmd_bank_q, cmd_bank_d;
    logic [ROW_WIDTH-1:0]   cmd_row_q, cmd_row_d;
    logic [COL_WIDTH-1:0]   cmd_col_q, cmd_col_d;
    logic                   ref_ack_q, ref_ack_d;

    logic [2:0]             iss_type;
    logic [BANK_WIDTH-1:0]  iss_bank;
    logic [ROW_WIDTH-1:0]   iss_row;
    logic [COL_WIDTH-1:0]   iss_col;
    logic                   tras_all_zero;

    always_comb begin
        tras_all_zero = 1'b1;
        for (int i = 0; i < NB; i++) begin
            if (tras_q[i] != 8'd0) tras_all_zero = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        rdy_d      = rdy_q;
        wait_d     = (wait_q != 8'd0) ? wait_q - 8'd1 : 8'd0;
        open_d     = open_q;
        for (int i = 0; i < NB; i++) begin
            row_d[i]  = row_q[i];
            tras_d[i] = (tras_q[i] != 8'd0) ? tras_q[i] - 8'd1 : 8'd0;
        end
        rq_write_d = rq_write_q;
        rq_bank_d  = rq_bank_q;
        rq_row_d   = rq_row_q;
        rq_col_d   = rq_col_q;
        iss_type   = C_NOP;
        iss_bank   = '0;
        iss_row    = '0;
        iss_col    = '0;

        // Decide now what goes on the command bus next cycle.
        case (state_q)
            S_IDLE: begin
                rdy_d = 1'b1;
                if (rdy_q && ref_req) begin
                    rdy_d = 1'b0;
                    if (open_q == '0)       iss_type = C_REF;
                    else if (tras_all_zero) iss_type = C_PREA;
                    else                    state_d  = S_PREA;
                end else if (rdy_q && req_valid) begin
                    rdy_d      = 1'b0;
                    rq_write_d = req_write;
                    rq_bank_d  = req_bank;
                    rq_row_d   = req_row;
                    rq_col_d   = req_col;
                    iss_bank   = req_bank;
                    if (!open_q[req_bank]) begin
                        iss_type = C_ACT;
                        iss_row  = req_row;
                    end else if (row_q[req_bank] == req_row) begin
                        iss_type = req_write ? C_WR : C_RD;
                        iss_col  = req_col;
                    end else if (tras_q[req_bank] == 8'd0) begin
                        iss_type = C_PRE;
                    end else begin
                        state_d = S_PRE;
                    end
                end
            end
            S_PRE: if (tras_q[rq_bank_q] == 8'd0) begin
                iss_type = C_PRE;
                iss_bank = rq_bank_q;
            end
            S_ACT: if (wait_q == 8'd0) begin
                iss_type = C_ACT;
                iss_bank = rq_bank_q;
                iss_row  = rq_row_q;
            end
            S_RW: if (wait_q == 8'd0) begin
                iss_type = rq_write_q ? C_WR : C_RD;
                iss_bank = rq_bank_q;
                iss_col  = rq_col_q;
            end
            S_PREA: if (tras_all_zero) iss_type = C_PREA;
            S_REF:  if (wait_q == 8'd0) iss_type = C_REF;
            S_WAIT_RFC: if (wait_q == 8'd0) begin
                state_d = S_IDLE;
                rdy_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                rdy_d   = 1'b0;
            end
        endcase

        cmd_valid_d = (iss_type != C_NOP);
        cmd_type_d  = iss_type;
        cmd_bank_d  = cmd_valid_d ? iss_bank : '0;
        cmd_row_d   = cmd_valid_d ? iss_row : '0;
        cmd_col_d   = cmd_valid_d ? iss_col : '0;
        ref_ack_d   = 1'b0;

        case (iss_type)
            C_ACT: begin
                open_d[iss_bank] = 1'b1;
                row_d[iss_bank]  = iss_row;
                tras_d[iss_bank] = 8'(T_RAS - 1);
                wait_d           = 8'(T_RCD - 1);
                state_d          = S_RW;
            end
            C_PRE: begin
                open_d[iss_bank] = 1'b0;
                wait_d           = 8'(T_RP - 1);
                state_d          = S_ACT;
            end
            C_RD, C_WR: state_d = S_IDLE;
            C_PREA: begin
                open_d  = '0;
                wait_d  = 8'(T_RP - 1);
                state_d = S_REF;
            end
            C_REF: begin
                ref_ack_d = 1'b1;
                wait_d    = 8'(T_RFC - 1);
                state_d   = S_WAIT_RFC;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b0;
            wait_q      <= 8'd0;
            open_q      <= '0;
            for (int i = 0; i < NB; i++) begin
                row_q[i]  <= '0;
                tras_q[i] <= 8'd0;
            end
            rq_write_q  <= 1'b0;
            rq_bank_q   <= '0;
            rq_row_q    <= '0;
            rq_col_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= C_NOP;
            cmd_bank_q  <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            ref_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            wait_q      <= wait_d;
            open_q      <= open_d;
            for (int i = 0; i < NB; i++) begin
                row_q[i]  <= row_d[i];
                tras_q[i] <= tras_d[i];
            end
            rq_write_q  <= rq_write_d;
            rq_bank_q   <= rq_bank_d;
            rq_row_q    <= rq_row_d;
            rq_col_q    <= rq_col_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            cmd_bank_q  <= cmd_bank_d;
            cmd_row_q   <= cmd_row_d;
            cmd_col_q   <= cmd_col_d;
            ref_ack_q   <= ref_ack_d;
        end
    end

    assign req_ready = rdy_q && !ref_req && (state_q == S_IDLE);
    assign ref_ack   = ref_ack_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_type  = cmd_type_q;
    assign cmd_bank  = cmd_bank_q;
    assign cmd_row   = cmd_row_q;
    assign cmd_col   = cmd_col_q;
    assign bank_open = open_q;
endmodule

// File: tb/tb_openddr_cmd_sequencer.sv
// Bench for openddr_cmd_sequencer: a cycle-arithmetic timing model schedules the
// expected command stream; directed scenarios pin the key cycles by hand.
module tb_openddr_cmd_sequencer;
    localparam int BW = 3, RWD = 16, CW = 10;
    localparam int T_RCD = 4, T_RP = 4, T_RAS = 10, T_RFC = 20;
    localparam int NB = 8, N = 2048;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_write = 1'b0;
    logic [BW-1:0]  req_bank = '0;
    logic [RWD-1:0] req_row = '0;
    logic [CW-1:0]  req_col = '0;
    logic           ref_req = 1'b0;
    logic           ref_ack;
    logic           cmd_valid;
    logic [2:0]     cmd_type;
    logic [BW-1:0]  cmd_bank;
    logic [RWD-1:0] cmd_row;
    logic [CW-1:0]  cmd_col;
    logic [NB-1:0]  bank_open;

    openddr_cmd_sequencer #(
        .BANK_WIDTH(BW), .ROW_WIDTH(RWD), .COL_WIDTH(CW),
        .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_RFC(T_RFC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
        .ref_req(ref_req), .ref_ack(ref_ack),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .bank_open(bank_open)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int exp_typ [N];
    int exp_bank[N];
    int exp_row [N];
    int exp_col [N];
    bit m_open[NB];
    int m_row [NB];
    int m_act [NB];
    int ready_cyc = 0;
    int acc_cnt = 0;
    int acc_t = 0;
    logic [NB-1:0] bo_m = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got 0x%0h want 0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void sched(input int t, input int ty, input int b, input int r, input int c);
        if (t >= 0 && t < N) begin
            exp_typ[t] = ty; exp_bank[t] = b; exp_row[t] = r; exp_col[t] = c;
        end
    endfunction

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            exp_typ[i] = 0; exp_bank[i] = 0; exp_row[i] = 0; exp_col[i] = 0;
        end
    end

    // Timing model: plan every command of a request/refresh the moment it starts.
    always @(posedge clk) begin : model
        int b, r, c, ty, rw, a, p, rf;
        bit any;
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                m_open[i] = 1'b0; m_act[i] = -1000; m_row[i] = 0;
            end
            ready_cyc = cyc + 2;
        end else if (cyc >= ready_cyc && ref_req) begin
            any = 1'b0;
            p = cyc + 1;
            for (int i = 0; i < NB; i++) begin
                if (m_open[i]) begin
                    any = 1'b1;
                    p = imax(p, m_act[i] + T_RAS);
                end
            end
            if (any) begin
                sched(p, 6, 0, 0, 0);
                rf = p + T_RP;
            end else begin
                rf = cyc + 1;
            end
            sched(rf, 5, 0, 0, 0);
            ready_cyc = rf + T_RFC;
            for (int i = 0; i < NB; i++) m_open[i] = 1'b0;
        end else if (cyc >= ready_cyc && req_valid) begin
            b = int'(req_bank); r = int'(req_row); c = int'(req_col);
            ty = req_write ? 3 : 2;
            if (m_open[b] && m_row[b] == r) begin
                rw = imax(cyc + 1, m_act[b] + T_RCD);
            end else begin
                a = cyc + 1;
                if (m_open[b]) begin
                    p = imax(cyc + 1, m_act[b] + T_RAS);
                    sched(p, 4, b, 0, 0);
                    a = p + T_RP;
                end
                sched(a, 1, b, r, 0);
                m_open[b] = 1'b1; m_row[b] = r; m_act[b] = a;
                rw = a + T_RCD;
            end
            sched(rw, ty, b, 0, c);
            ready_cyc = rw + 1;
            acc_cnt++;
            acc_t = cyc;
        end
        cyc++;
    end

    always @(negedge clk) begin : compare
        int ty;
        if (rst) begin
            for (int t = cyc; t < N; t++) exp_typ[t] = 0;
            bo_m = '0;
            chk("rst_cmd_valid", cmd_valid, 0);
            chk("rst_cmd_type", cmd_type, 0);
            chk("rst_cmd_bank", cmd_bank, 0);
            chk("rst_cmd_row", cmd_row, 0);
            chk("rst_cmd_col", cmd_col, 0);
            chk("rst_ref_ack", ref_ack, 0);
            chk("rst_bank_open", bank_open, 0);
            chk("rst_req_ready", req_ready, 0);
        end else begin
            ty = (cyc < N) ? exp_typ[cyc] : 0;
            if (ty == 1) bo_m[exp_bank[cyc]] = 1'b1;
            if (ty == 4) bo_m[exp_bank[cyc]] = 1'b0;
            if (ty == 6) bo_m = '0;
            chk("cmd_valid", cmd_valid, ty != 0);
            chk("cmd_type", cmd_type, ty);
            chk("cmd_bank", cmd_bank, (ty != 0) ? exp_bank[cyc] : 0);
            chk("cmd_row", cmd_row, (ty != 0) ? exp_row[cyc] : 0);
            chk("cmd_col", cmd_col, (ty != 0) ? exp_col[cyc] : 0);
            chk("ref_ack", ref_ack, ty == 5);
            chk("bank_open", bank_open, bo_m);
            chk("req_ready", req_ready, (cyc >= ready_cyc) && !ref_req);
        end
    end

    task automatic at_cyc(input int t);
        int k;
        k = 0;
        while (cyc < t && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (cyc != t) begin
            checks++; errors++;
            $display("FAIL at_cyc now %0d want %0d", cyc, t);
        end
    endtask

    task automatic exp_cmd(input string nm, input int t, input int ty, input int b, input int r, input int c);
        at_cyc(t);
        chk({nm, "_valid"}, cmd_valid, 1);
        chk({nm, "_type"}, cmd_type, ty);
        chk({nm, "_bank"}, cmd_bank, b);
        chk({nm, "_row"}, cmd_row, r);
        chk({nm, "_col"}, cmd_col, c);
    endtask

    task automatic wait_acc(input int n0, output int t);
        int k;
        k = 0;
        while (acc_cnt == n0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (acc_cnt == n0) begin
            checks++; errors++;
            $display("FAIL accept_timeout cycle %0d", cyc);
        end
        req_valid = 1'b0;
        t = acc_t;
    endtask

    task automatic issue(input bit w, input int b, input int r, input int c, output int t);
        int n0;
        @(posedge clk); #1;
        n0 = acc_cnt;
        req_valid = 1'b1; req_write = w;
        req_bank = BW'(b); req_row = RWD'(r); req_col = CW'(c);
        wait_acc(n0, t);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", req_ready, 1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a, a2, a3, r0, n0;
        do_reset();

        // closed bank, then row hit
        issue(0, 2, 'h1234, 'h010, a);
        exp_cmd("act_closed", a + 1, 1, 2, 'h1234, 0);
        exp_cmd("rd_closed", a + 5, 2, 2, 0, 'h010);
        chk("bank_open_after_act", bank_open, 'h04);
        issue(1, 2, 'h1234, 'h020, a2);
        chk("hit_accept_cycle", a2 - a, 6);
        exp_cmd("wr_hit", a2 + 1, 3, 2, 0, 'h020);

        // row miss with tRAS long satisfied
        issue(0, 0, 7, 3, a);
        at_cyc(a + 20);
        issue(0, 0, 8, 4, a2);
        exp_cmd("pre_met", a2 + 1, 4, 0, 0, 0);
        exp_cmd("act_met", a2 + 5, 1, 0, 8, 0);
        exp_cmd("rd_met", a2 + 9, 2, 0, 0, 4);
        chk("bank_open_two", bank_open, 'h05);

        // row miss under tRAS
        do_reset();
        issue(0, 2, 'h1234, 'h010, a);
        issue(0, 2, 'h5678, 'h010, a2);
        chk("miss_accept_cycle", a2 - a, 6);
        exp_cmd("pre_tras", a + 11, 4, 2, 0, 0);
        exp_cmd("act_miss", a + 15, 1, 2, 'h5678, 0);
        exp_cmd("rd_miss", a + 19, 2, 2, 0, 'h010);

        // refresh with a bank open and tRAS met, racing a request
        at_cyc(a + 26);
        @(posedge clk); #1;
        r0 = cyc;
        n0 = acc_cnt;
        ref_req = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_bank = 3'd5; req_row = 16'h0042; req_col = 10'h011;
        #1 chk("ref_blocks_ready", req_ready, 0);
        exp_cmd("prea", r0 + 1, 6, 0, 0, 0);
        exp_cmd("ref", r0 + 5, 5, 0, 0, 0);
        chk("ref_ack_pulse", ref_ack, 1);
        chk("ref_bank_open", bank_open, 0);
        @(posedge clk); #1;
        ref_req = 1'b0;
        at_cyc(r0 + 24);
        chk("rfc_not_ready", req_ready, 0);
        at_cyc(r0 + 25);
        chk("rfc_ready", req_ready, 1);
        wait_acc(n0, a3);
        chk("post_ref_accept", a3 - r0, 25);
        exp_cmd("act_post_ref", a3 + 1, 1, 5, 'h42, 0);
        exp_cmd("rd_post_ref", a3 + 5, 2, 5, 0, 'h011);

        // refresh while tRAS not yet met
        @(posedge clk); #1;
        ref_req = 1'b1;
        exp_cmd("prea_tras", a3 + 11, 6, 0, 0, 0);
        exp_cmd("ref_tras", a3 + 15, 5, 0, 0, 0);
        @(posedge clk); #1;
        ref_req = 1'b0;
        at_cyc(a3 + 35);
        chk("rfc2_ready", req_ready, 1);

        // refresh with no bank open
        do_reset();
        @(posedge clk); #1;
        r0 = cyc;
        ref_req = 1'b1;
        exp_cmd("ref_direct", r0 + 1, 5, 0, 0, 0);
        chk("ref_direct_ack", ref_ack, 1);
        @(posedge clk); #1;
        ref_req = 1'b0;
        at_cyc(r0 + 21);
        chk("ref_direct_ready", req_ready, 1);

        // reset in the cycle after ACT drops the request
        issue(0, 3, 'h0abc, 5, a);
        exp_cmd("act_before_rst", a + 1, 1, 3, 'h0abc, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", cmd_valid, 0);
        chk("rst_mid_bank_open", bank_open, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_open_after", bank_open, 0);
        at_cyc(cyc + 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/openddr_cmd_sequencer.md
OPENDDR_CMD_SEQUENCER -- requirements
Module: openddr_cmd_sequencer

Interface
REQ-001 SHALL have parameter BANK_WIDTH, default 3, meaning bank address width (2**BANK_WIDTH banks).
REQ-002 SHALL have parameter ROW_WIDTH, default 16, meaning row address width.
REQ-003 SHALL have parameter COL_WIDTH, default 10, meaning column address width.
REQ-004 SHALL have parameters T_RCD=4, T_RP=4, T_RAS=10, T_RFC=20, each in clk cycles with legal range 1..255.
REQ-005 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-009 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-010 SHALL have ports req_bank / req_row / req_col  input  BANK_WIDTH / ROW_WIDTH / COL_WIDTH  decoded target address.
REQ-011 SHALL have port ref_req  input  1  refresh request, level, held until ref_ack.
REQ-012 SHALL have port ref_ack  output  1  one-cycle pulse in the REF command cycle.
REQ-013 SHALL have port cmd_valid  output  1  one-cycle command strobe; no backpressure.
REQ-014 SHALL have port cmd_type  output  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6 PREA.
REQ-015 SHALL have ports cmd_bank / cmd_row / cmd_col  output  BANK_WIDTH / ROW_WIDTH / COL_WIDTH  command address.
REQ-016 SHALL have port bank_open  output  2**BANK_WIDTH  per-bank open-row flag.

Function
REQ-017 SHALL keep a per-bank open-row table: open flag, open row, and a tRAS down-counter of 8 bits.
REQ-018 SHALL implement the FSM states IDLE, PRE, ACT, RW, PREA, REF, WAIT_RFC, with at most one request outstanding.
REQ-019 SHALL assert req_ready only in IDLE with ref_req low; it SHALL capture req_* on acceptance.
REQ-020 SHALL, on acceptance, go to RW if the bank is open and the row matches (hit), to PRE if the bank is open and the row differs (miss), and to ACT if the bank is closed.
REQ-021 SHALL issue each command with cmd_valid=1 for exactly one cycle; cmd_type is NOP and cmd_valid is 0 in all other cycles.
REQ-022 SHALL issue the first command no earlier than the cycle after acceptance.
REQ-023 SHALL issue PRE/PREA to a bank no earlier than ACT cycle + T_RAS, ACT no earlier than PRE/PREA cycle + T_RP, and RD/WR no earlier than ACT cycle + T_RCD.
REQ-024 SHALL issue each command in the first cycle its constraints allow; there SHALL be no extra idle cycles.
REQ-025 SHALL set a bank's open flag and row on ACT and clear it on PRE; PREA SHALL clear all open flags.
REQ-026 SHALL return to IDLE in the cycle after RD/WR, so req_ready is high in that next cycle.
REQ-027 SHALL, when ref_req is high in IDLE, give refresh priority over any simultaneous req_valid (req_ready=0).
REQ-028 SHALL, on refresh with any bank open: issue PREA at the first tRAS-legal cycle covering all banks, then REF at PREA + T_RP.
REQ-029 SHALL, on refresh with no bank open: issue REF in the next cycle.
REQ-030 SHALL pulse ref_ack in the REF cycle and SHALL hold req_ready low until REF cycle + T_RFC.
REQ-031 SHALL drive cmd_row/cmd_col to zero for commands that do not use them; cmd_bank SHALL be zero for REF and PREA.

Reset
REQ-032 SHALL, while rst is high, immediately force state IDLE, all open flags and counters 0, and cmd_valid, req_ready, ref_ack, cmd_type, cmd_bank, cmd_row, cmd_col, bank_open to 0.
REQ-033 SHALL drop any in-flight request on reset mid-operation, with no command issued for it.
REQ-034 SHALL raise req_ready in the first clk cycle after rst deasserts, if ref_req is low.

Verification (default parameters, acceptance cycle = 0)
REQ-035 Closed bank: read bank 2, row 0x1234, col 0x010 -> ACT(2,0x1234) at cycle 1, RD(2,col 0x010) at cycle 5, bank_open=0x04.
REQ-036 Row hit: continuing REQ-035, write to bank 2, row 0x1234, col 0x020 accepted at cycle 6 -> WR at cycle 7, with no ACT.
REQ-037 Row miss under tRAS: after REQ-035, read bank 2, row 0x5678 accepted at cycle 6 -> PRE(2) at cycle 11, ACT(2,0x5678) at cycle 15, RD at cycle 19.
REQ-038 Refresh: bank 2 open and tRAS met, ref_req and req_valid rise together at cycle 0 -> req_ready=0, PREA at cycle 1, REF+ref_ack at cycle 5, bank_open=0, req_ready=1 at cycle 25.
REQ-039 Refresh with no bank open: ref_req at cycle 0 -> REF at cycle 1, no PREA.
REQ-040 Reset mid-operation: rst asserted in the cycle after ACT -> cmd_valid 0 immediately, no RD issued, bank_open=0, req_ready=1 in the first cycle after release.
